systolic_row: RTL and testbench

//  Parametrised 1xN output-stationary systolic row: N PEs share one B operand stream shifted

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_pe.sv | 86 ++++++++
 rtl/systolic_row.sv | 154 +++++++++++++++
 tb/tb_systolic_row.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic_row datapath.
//   - Default widths for the row parameters.
//   - tok_t: control token that travels alongside the B operand from PE to PE.
//   - ACC_MAX: saturation ceiling at the default accumulator width.
//   Optional feature macro used by this design: SYSTOLIC_SAT_EN.
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_A_W   = 16;
  localparam int DEF_B_W   = 16;
  localparam int DEF_ACC_W = 32;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

  // Framing for one beat. The B value rides in a separate, width-parametrised
  // register next to this token.
  typedef struct packed {
    logic valid;  // beat present
    logic first;  // beat opens a new dot-product stream
    logic last;   // beat closes the current stream
  } tok_t;

endpackage

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
//   One multiply-accumulate processing element of the systolic row.
//   Macro: SYSTOLIC_SAT_EN -- when defined the accumulator saturates at
//   2^ACC_W-1 and raises a sticky per-stream overflow flag; otherwise the
//   accumulator wraps modulo 2^ACC_W and res_ovf is 0.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   tok_valid  in   token at this PE carries a beat
//   tok_first  in   the beat opens a new stream (restart accumulation)
//   a          in   A operand already skewed to meet this beat
//   b          in   B operand of the beat
//   res        out  accumulator value being written this cycle
//   res_ovf    out  sticky overflow state being written this cycle
// -----------------------------------------------------------------------------
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  input  logic             tok_first,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] res,
  output logic             res_ovf
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] base;

  always_comb begin
    prod = ACC_W'(a) * ACC_W'(b);
    // A first beat discards the previous stream's total.
    base = tok_first ? '0 : acc_q;
  end

`ifdef SYSTOLIC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = '1;

  logic             ovf_q;
  logic             ovf_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, base} + {1'b0, prod};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (tok_valid) begin
      // Once clamped, the stream stays pinned at the ceiling.
      ovf_d = (~tok_first & ovf_q) | sum[ACC_W];
      acc_d = ovf_d ? SAT_MAX : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign res_ovf = ovf_d;
`else
  always_comb begin
    acc_d = tok_valid ? (base + prod) : acc_q;
  end

  assign res_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  // Expose the value being written so the final total is available on the
  // same edge the last beat is accumulated.
  assign res = acc_d;

endmodule

// File: rtl/systolic_row.sv
// -----------------------------------------------------------------------------
// systolic_row
//   1xN output-stationary systolic row. A shared B stream is shifted one PE per
//   cycle; column i's A operand is delayed i cycles to meet it. Per-column
//   results are deskewed so that all columns land in c together, one cycle
//   pulse on out_valid per completed stream.
//   Macro: SYSTOLIC_SAT_EN -- saturating accumulators with ovf reporting;
//   undefined: wrap-around arithmetic and ovf is always 0.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   in_valid   in   a/b/in_last carry a beat this cycle
//   in_last    in   beat closes the current dot-product stream
//   a          in   N*A_W A operands, column i at [i*A_W +: A_W]
//   b          in   shared B operand
//   c          out  N*ACC_W results, column i at [i*ACC_W +: ACC_W]
//   out_valid  out  one-cycle pulse, c holds a newly completed stream
//   ovf        out  overflow in the reported stream (only with out_valid)
// -----------------------------------------------------------------------------
module systolic_row
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [N*A_W-1:0]   a,
  input  logic [B_W-1:0]     b,
  output logic [N*ACC_W-1:0] c,
  output logic               out_valid,
  output logic               ovf
);

  tok_t             tok_pe [N];
  logic [B_W-1:0]   b_pe   [N];
  logic [A_W-1:0]   a_pe   [N];
  logic [ACC_W-1:0] res_pe [N];
  logic             ovf_pe [N];

  logic [N*ACC_W-1:0] land_res;
  logic [N-1:0]       land_ovf;

  logic               start_q, start_d;
  logic [N*ACC_W-1:0] c_q, c_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_q, ovf_d;
  logic               fire;

  assign tok_pe[0] = '{valid: in_valid, first: start_q, last: in_last};
  assign b_pe[0]   = b;

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    if (gi > 0) begin : g_pipe
      tok_t           tok_q;
      logic [B_W-1:0] b_q;
      logic [A_W-1:0] a_sr_q [gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tok_q <= '0;
          b_q   <= '0;
          for (int j = 0; j < gi; j++) a_sr_q[j] <= '0;
        end else begin
          tok_q     <= tok_pe[gi-1];
          b_q       <= b_pe[gi-1];
          a_sr_q[0] <= a[gi*A_W +: A_W];
          for (int j = 1; j < gi; j++) a_sr_q[j] <= a_sr_q[j-1];
        end
      end

      assign tok_pe[gi] = tok_q;
      assign b_pe[gi]   = b_q;
      assign a_pe[gi]   = a_sr_q[gi-1];
    end else begin : g_head
      assign a_pe[0] = a[A_W-1:0];
    end

    systolic_pe #(
      .A_W   (A_W),
      .B_W   (B_W),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk       (clk),
      .rst       (rst),
      .tok_valid (tok_pe[gi].valid),
      .tok_first (tok_pe[gi].first),
      .a         (a_pe[gi]),
      .b         (b_pe[gi]),
      .res       (res_pe[gi]),
      .res_ovf   (ovf_pe[gi])
    );

    // Column gi finishes a stream gi cycles after column 0; delay it by the
    // remaining N-1-gi cycles so every column is ready when the last one is.
    if (gi == N-1) begin : g_land
      assign land_res[gi*ACC_W +: ACC_W] = res_pe[gi];
      assign land_ovf[gi]                = ovf_pe[gi];
    end else begin : g_dsk
      localparam int D = N - 1 - gi;
      logic [ACC_W:0] dsk_q [D];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j < D; j++) dsk_q[j] <= '0;
        end else begin
          dsk_q[0] <= {ovf_pe[gi], res_pe[gi]};
          for (int j = 1; j < D; j++) dsk_q[j] <= dsk_q[j-1];
        end
      end

      assign land_res[gi*ACC_W +: ACC_W] = dsk_q[D-1][ACC_W-1:0];
      assign land_ovf[gi]                = dsk_q[D-1][ACC_W];
    end
  end

  // The last beat of a stream reaching the final PE completes the stream.
  assign fire = tok_pe[N-1].valid & tok_pe[N-1].last;

  always_comb begin
    start_d     = start_q;
    c_d         = c_q;
    out_valid_d = fire;
    ovf_d       = 1'b0;
    if (in_valid) start_d = in_last;
    if (fire) begin
      c_d   = land_res;
      ovf_d = |land_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q     <= 1'b1;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      start_q     <= start_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_row.sv
// -----------------------------------------------------------------------------
// tb_systolic_row
//   Self-checking bench for systolic_row (N=4, 16x16 operands, 32-bit acc).
//   Reference: per-column dot products accumulated at the input side, each
//   completed stream queued with the edge on which its result must appear.
//   Macro: SYSTOLIC_SAT_EN selects saturating expectations.
// -----------------------------------------------------------------------------
module tb_systolic_row;

  localparam int N     = 4;
  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int ACC_W = 32;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic [N*A_W-1:0]   a = '0;
  logic [B_W-1:0]     b = '0;
  logic [N*ACC_W-1:0] c;
  logic               out_valid;
  logic               ovf;

  systolic_row #(
    .N     (N),
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    int                 due;
    logic [N*ACC_W-1:0] cv;
    logic               ov;
  } exp_t;

  exp_t               exp_q[$];
  longint unsigned    m_acc [N];
  bit                 m_sat [N];
  bit                 m_start = 1'b1;
  int                 edge_cnt = 0;
  logic [N*ACC_W-1:0] last_c = '0;

  always @(posedge clk or negedge rst) begin : model
    exp_t            e;
    longint unsigned p;
    if (!rst) begin
      exp_q.delete();
      m_start = 1'b1;
      last_c  = '0;
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0;
        m_sat[i] = 1'b0;
      end
    end else begin
      edge_cnt++;
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          p = 64'(a[i*A_W +: A_W]) * 64'(b);
          if (m_start) begin
            m_acc[i] = 0;
            m_sat[i] = 1'b0;
          end
`ifdef SYSTOLIC_SAT_EN
          if (m_sat[i] || (m_acc[i] + p > MAXV)) begin
            m_acc[i] = MAXV;
            m_sat[i] = 1'b1;
          end else begin
            m_acc[i] = m_acc[i] + p;
          end
`else
          m_acc[i] = (m_acc[i] + p) & MAXV;
`endif
        end
        m_start = in_last;
        if (in_last) begin
          e.due = edge_cnt + N - 1;
          e.ov  = 1'b0;
          for (int i = 0; i < N; i++) begin
            e.cv[i*ACC_W +: ACC_W] = ACC_W'(m_acc[i]);
            e.ov = e.ov | m_sat[i];
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [N*ACC_W-1:0] pulse_q[$];
  logic               pulse_ovf_q[$];
  int                 pulse_edge_q[$];

  always @(negedge clk) begin : compare
    if (!rst) begin
      chk("rst_c", c, '0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
    end else if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
      chk("pulse_out_valid", out_valid, 1'b1);
      chk("pulse_c", c, exp_q[0].cv);
      chk("pulse_ovf", ovf, exp_q[0].ov);
      last_c = exp_q[0].cv;
      void'(exp_q.pop_front());
    end else begin
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_ovf", ovf, 1'b0);
      chk("idle_c_hold", c, last_c);
    end
    if (rst && out_valid) begin
      $display("pulse edge=%0d c=%h ovf=%0b", edge_cnt, c, ovf);
      pulse_q.push_back(c);
      pulse_ovf_q.push_back(ovf);
      pulse_edge_q.push_back(edge_cnt);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [N*A_W-1:0] pk(input logic [A_W-1:0] a3, input logic [A_W-1:0] a2,
                                          input logic [A_W-1:0] a1, input logic [A_W-1:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [ACC_W-1:0] col(input logic [N*ACC_W-1:0] v, input int i);
    return v[i*ACC_W +: ACC_W];
  endfunction

  task automatic beat(input bit v, input bit l, input logic [N*A_W-1:0] av, input logic [B_W-1:0] bv);
    in_valid = v;
    in_last  = l;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input int n, input string name);
    int t = 0;
    while (pulse_q.size() < n && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(name, pulse_q.size() >= n, 1'b1);
  endtask

  task automatic clear_pulses();
    pulse_q.delete();
    pulse_ovf_q.delete();
    pulse_edge_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int               acc_e;
    logic [N*A_W-1:0] av;
    logic [31:0]      exp_c0;
    logic             exp_ov;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_c", c, '0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Single beat, valid+last: products land together N-1 edges later
    clear_pulses();
    beat(1'b1, 1'b1, pk(16'd4, 16'd3, 16'd2, 16'd1), 16'd10);
    acc_e = edge_cnt;
    wait_pulses(1, "t2_pulse_seen");
    if (pulse_q.size() >= 1) begin
      chk("t2_c0", col(pulse_q[0], 0), 32'd10);
      chk("t2_c1", col(pulse_q[0], 1), 32'd20);
      chk("t2_c2", col(pulse_q[0], 2), 32'd30);
      chk("t2_c3", col(pulse_q[0], 3), 32'd40);
      chk("t2_latency", pulse_edge_q[0] - acc_e, N - 1);
    end
    idle(3);

    // Reset mid-stream: in-flight last beat must never produce a pulse
    clear_pulses();
    beat(1'b1, 1'b0, pk(16'd1, 16'd1, 16'd1, 16'd1), 16'd5);
    beat(1'b1, 1'b1, pk(16'd1, 16'd1, 16'd1, 16'd1), 16'd6);
    rst = 1'b0;
    #1;
    chk("t1_async_c", c, '0);
    chk("t1_async_out_valid", out_valid, 1'b0);
    chk("t1_async_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(8);
    chk("t1_no_pulse", pulse_q.size(), 0);

    // Two-beat stream on columns 0/1
    clear_pulses();
    beat(1'b1, 1'b0, pk(16'd0, 16'd0, 16'd5, 16'd5), 16'd10);
    beat(1'b1, 1'b1, pk(16'd0, 16'd0, 16'd5, 16'd20), 16'd15);
    wait_pulses(1, "t3_pulse_seen");
    idle(5);
    chk("t3_one_pulse", pulse_q.size(), 1);
    if (pulse_q.size() >= 1) begin
      chk("t3_c0", col(pulse_q[0], 0), 32'd350);
      chk("t3_c1", col(pulse_q[0], 1), 32'd125);
    end

    // Stream with a bubble, then a back-to-back length-1 stream
    clear_pulses();
    beat(1'b1, 1'b0, pk(16'd2, 16'd2, 16'd2, 16'd2), 16'd1);
    beat(1'b0, 1'b0, pk(16'd9, 16'd9, 16'd9, 16'd9), 16'd9);
    beat(1'b1, 1'b0, pk(16'd2, 16'd2, 16'd2, 16'd2), 16'd2);
    beat(1'b1, 1'b1, pk(16'd2, 16'd2, 16'd2, 16'd2), 16'd3);
    beat(1'b1, 1'b1, pk(16'd1, 16'd1, 16'd1, 16'd1), 16'd7);
    wait_pulses(2, "t4_pulses_seen");
    if (pulse_q.size() >= 2) begin
      for (int i = 0; i < N; i++) begin
        chk("t4_first_c", col(pulse_q[0], i), 32'd12);
        chk("t4_second_c", col(pulse_q[1], i), 32'd7);
      end
      chk("t4_adjacent", pulse_edge_q[1] - pulse_edge_q[0], 1);
    end
    idle(3);

    // Overflow: two full-scale products in column 0
`ifdef SYSTOLIC_SAT_EN
    exp_c0 = 32'hFFFF_FFFF;
    exp_ov = 1'b1;
`else
    exp_c0 = 32'hFFFC_0002;
    exp_ov = 1'b0;
`endif
    clear_pulses();
    beat(1'b1, 1'b0, pk(16'd0, 16'd0, 16'd0, 16'hFFFF), 16'hFFFF);
    beat(1'b1, 1'b1, pk(16'd0, 16'd0, 16'd0, 16'hFFFF), 16'hFFFF);
    wait_pulses(1, "t5_pulse_seen");
    if (pulse_q.size() >= 1) begin
      chk("t5_c0", col(pulse_q[0], 0), exp_c0);
      chk("t5_c1", col(pulse_q[0], 1), 32'd0);
      chk("t5_ovf", pulse_ovf_q[0], exp_ov);
    end

    // Hold: c keeps the last result while idle
    idle(10);
    chk("t6_no_new_pulse", pulse_q.size(), 1);
    chk("t6_c0_hold", col(c, 0), exp_c0);
    chk("t6_out_valid_low", out_valid, 1'b0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        av[i*A_W +: A_W] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      beat($urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0, av,
           ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
      if (n == 200) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
      end
    end
    idle(10);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
